// File: rtl/regfile_seq_ctrl_if.sv
// Bus bundle for the register-file sequencer: CPU writeback, host preload handshake,
// and the register file write port plus status.
interface regfile_seq_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              cpu_we3;
  logic [3:0]        cpu_wa3;
  logic [DATA_W-1:0] cpu_wd3;
  logic              host_valid;
  logic              host_ready;
  logic [3:0]        host_addr;
  logic [DATA_W-1:0] host_data;
  logic              host_load_done;
  logic              we3;
  logic [3:0]        wa3;
  logic [DATA_W-1:0] wd3;
  logic              cpu_stall;
  logic [1:0]        ctrl_state;
  logic              bad_addr_err;

  modport master (
    output cpu_we3, cpu_wa3, cpu_wd3,
    output host_valid, host_addr, host_data, host_load_done,
    input  host_ready, we3, wa3, wd3, cpu_stall, ctrl_state, bad_addr_err
  );

  modport slave (
    input  cpu_we3, cpu_wa3, cpu_wd3,
    input  host_valid, host_addr, host_data, host_load_done,
    output host_ready, we3, wa3, wd3, cpu_stall, ctrl_state, bad_addr_err
  );
endinterface

// File: rtl/regfile_seq_ctrl.sv
// Register-file write-port sequencer: CLEAR sweep, host preload (LOAD), then CPU writeback (RUN).
// Define REGFILE_HOST_RUN_WR_EN to let the host fill idle writeback cycles during RUN.
module regfile_seq_ctrl #(
  parameter int                NREGS     = 15,
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input logic               clk,
  input logic               reset,
  regfile_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'b00,
    ST_LOAD  = 2'b01,
    ST_RUN   = 2'b10
  } state_t;

  localparam logic [3:0] LAST_IDX  = 4'(NREGS - 1);
  localparam logic [4:0] NREGS_LIM = 5'(NREGS);

  state_t            state, state_nx;
  logic [3:0]        clr_idx, clr_idx_nx;
  logic              err, err_nx;

  logic              we3_c;
  logic [3:0]        wa3_c;
  logic [DATA_W-1:0] wd3_c;
  logic              host_ready_c;
  logic              cpu_stall_c;
  logic              host_ok;
  logic              cpu_ok;

  assign host_ok = {1'b0, bus.host_addr} < NREGS_LIM;
  assign cpu_ok  = {1'b0, bus.cpu_wa3}   < NREGS_LIM;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_CLEAR;
      clr_idx <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_nx;
      clr_idx <= clr_idx_nx;
      err     <= err_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    clr_idx_nx   = clr_idx;
    err_nx       = err;
    we3_c        = 1'b0;
    wa3_c        = '0;
    wd3_c        = '0;
    host_ready_c = 1'b0;
    cpu_stall_c  = 1'b1;

    case (state)
      ST_CLEAR: begin
        we3_c      = 1'b1;
        wa3_c      = clr_idx;
        wd3_c      = CLEAR_VAL;
        clr_idx_nx = clr_idx + 4'd1;
        if (clr_idx == LAST_IDX) begin
          clr_idx_nx = '0;
          state_nx   = ST_LOAD;
        end
      end

      ST_LOAD: begin
        host_ready_c = 1'b1;
        wa3_c        = bus.host_addr;
        wd3_c        = bus.host_data;
        // Out-of-range requests still complete the handshake so the host never stalls.
        if (bus.host_valid) begin
          if (host_ok) we3_c  = 1'b1;
          else         err_nx = 1'b1;
        end
        if (bus.host_load_done) state_nx = ST_RUN;
      end

      ST_RUN: begin
        cpu_stall_c = 1'b0;
        wa3_c       = bus.cpu_wa3;
        wd3_c       = bus.cpu_wd3;
        if (bus.cpu_we3) begin
          if (cpu_ok) we3_c  = 1'b1;
          else        err_nx = 1'b1;
        end
`ifdef REGFILE_HOST_RUN_WR_EN
        else begin
          // CPU writeback always wins; the host only gets cycles the CPU leaves idle.
          host_ready_c = 1'b1;
          if (bus.host_valid) begin
            wa3_c = bus.host_addr;
            wd3_c = bus.host_data;
            if (host_ok) we3_c  = 1'b1;
            else         err_nx = 1'b1;
          end
        end
`endif
      end

      default: begin
        state_nx   = ST_CLEAR;
        clr_idx_nx = '0;
      end
    endcase
  end

  assign bus.we3          = we3_c;
  assign bus.wa3          = wa3_c;
  assign bus.wd3          = wd3_c;
  assign bus.host_ready   = host_ready_c;
  assign bus.cpu_stall    = cpu_stall_c;
  assign bus.ctrl_state   = state;
  assign bus.bad_addr_err = err;

endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// Testbench for regfile_seq_ctrl: vector table, reset corner sequences and randomized RUN traffic
// checked against a rule-level model and a shadow register file.
module tb_regfile_seq_ctrl;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  bit   m_err;

`ifdef REGFILE_HOST_RUN_WR_EN
  localparam bit HOST_RUN = 1'b1;
`else
  localparam bit HOST_RUN = 1'b0;
`endif

  typedef struct {
    logic        rst;
    logic        cwe;
    logic [3:0]  cwa;
    logic [31:0] cwd;
    logic        hv;
    logic [3:0]  ha;
    logic [31:0] hd;
    logic        hdone;
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic        rdy;
    logic        stall;
    logic [1:0]  st;
    logic        err;
  } vec_t;

  logic [31:0] dmem [16];
  logic [31:0] mmem [16];
  vec_t        tbl  [7];

  regfile_seq_ctrl_if #(.DATA_W(32)) bus ();

  regfile_seq_ctrl #(.NREGS(15), .DATA_W(32), .CLEAR_VAL(32'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input logic rst, input logic cwe, input logic [3:0] cwa,
                              input logic [31:0] cwd, input logic hv, input logic [3:0] ha,
                              input logic [31:0] hd, input logic hdone, input logic we,
                              input logic [3:0] wa, input logic [31:0] wd, input logic rdy,
                              input logic stall, input logic [1:0] st, input logic err);
    vec_t v;
    v.rst = rst; v.cwe = cwe; v.cwa = cwa; v.cwd = cwd;
    v.hv = hv; v.ha = ha; v.hd = hd; v.hdone = hdone;
    v.we = we; v.wa = wa; v.wd = wd; v.rdy = rdy;
    v.stall = stall; v.st = st; v.err = err;
    return v;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string nm);
    reset              = v.rst;
    bus.cpu_we3        = v.cwe;
    bus.cpu_wa3        = v.cwa;
    bus.cpu_wd3        = v.cwd;
    bus.host_valid     = v.hv;
    bus.host_addr      = v.ha;
    bus.host_data      = v.hd;
    bus.host_load_done = v.hdone;
    #2;
    cmp({nm, ".we3"}, 32'(bus.we3), 32'(v.we));
    if (v.we) begin
      cmp({nm, ".wa3"}, 32'(bus.wa3), 32'(v.wa));
      cmp({nm, ".wd3"}, bus.wd3, v.wd);
    end
    cmp({nm, ".host_ready"}, 32'(bus.host_ready), 32'(v.rdy));
    cmp({nm, ".cpu_stall"}, 32'(bus.cpu_stall), 32'(v.stall));
    cmp({nm, ".ctrl_state"}, 32'(bus.ctrl_state), 32'(v.st));
    cmp({nm, ".bad_addr_err"}, 32'(bus.bad_addr_err), 32'(v.err));
    if (bus.we3 === 1'b1) dmem[bus.wa3] = bus.wd3;
    if (v.we) mmem[v.wa] = v.wd;
    @(posedge clk);
    #1;
  endtask

  // CLEAR sweep of n cycles with junk on every ignored input; optionally reset on the last one.
  task automatic sweep(input int n, input bit rst_last, input string nm);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v = mk(rst_last && (i == n - 1), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
             $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
             1'($urandom_range(0, 1)),
             1'b1, 4'(i), 32'h0, 1'b0, 1'b1, 2'b00, 1'b0);
      apply(v, $sformatf("%s[%0d]", nm, i));
    end
  endtask

  initial begin
    vec_t v;
    logic        cwe, hv, cw_ok, hw_ok, hr;
    logic [3:0]  cwa, ha;
    logic [31:0] cwd, hd;

    total = 0;
    bad   = 0;
    for (int i = 0; i < 16; i++) begin
      dmem[i] = 32'h0;
      mmem[i] = 32'h0;
    end

    // LOAD then RUN vectors, entered right after the first 15-cycle sweep.
    tbl[0] = mk(0, 0, 4'd0, 32'h0, 1, 4'd3,  32'hDEADBEEF, 0,
                1, 4'd3,  32'hDEADBEEF, 1, 1, 2'b01, 0);
    tbl[1] = mk(0, 1, 4'd7, 32'h99, 0, 4'd0, 32'h0, 0,
                0, 4'd0,  32'h0,        1, 1, 2'b01, 0);
    tbl[2] = mk(0, 0, 4'd0, 32'h0, 1, 4'd15, 32'h55, 0,
                0, 4'd0,  32'h0,        1, 1, 2'b01, 0);
    tbl[3] = mk(0, 0, 4'd0, 32'h0, 1, 4'd14, 32'h12345678, 1,
                1, 4'd14, 32'h12345678, 1, 1, 2'b01, 1);
    tbl[4] = mk(0, 1, 4'd5, 32'hA5A5A5A5, 1, 4'd2, 32'h1111, 0,
                1, 4'd5,  32'hA5A5A5A5, 0, 0, 2'b10, 1);
    tbl[5] = mk(0, 0, 4'd0, 32'h0, 1, 4'd2, 32'h1111, 0,
                HOST_RUN, 4'd2, 32'h1111, HOST_RUN, 0, 2'b10, 1);
    tbl[6] = mk(0, 1, 4'd15, 32'h77, 0, 4'd0, 32'h0, 0,
                0, 4'd0,  32'h0,        0, 0, 2'b10, 1);

    reset = 1'b1;
    bus.cpu_we3 = 0; bus.cpu_wa3 = 0; bus.cpu_wd3 = 0;
    bus.host_valid = 0; bus.host_addr = 0; bus.host_data = 0; bus.host_load_done = 0;
    repeat (2) @(posedge clk);
    #1;

    sweep(15, 1'b0, "clr0");
    for (int i = 0; i < 7; i++) apply(tbl[i], $sformatf("tbl[%0d]", i));

    for (int i = 0; i < 10; i++)
      apply(mk(0, 0, 4'd0, 32'h0, 1, 4'd4, 32'h4444_0000 + 32'(i), 0,
               HOST_RUN, 4'd4, 32'h4444_0000 + 32'(i), HOST_RUN, 0, 2'b10, 1),
            $sformatf("run_host[%0d]", i));

    // Reset out of RUN, then again at clr_idx=7, then again mid-LOAD.
    apply(mk(1, 0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 0, 0, 4'd0, 32'h0, HOST_RUN, 0, 2'b10, 1), "rst_run");
    sweep(8, 1'b1, "clr_abort");
    sweep(15, 1'b0, "clr1");
    apply(mk(0, 0, 4'd0, 32'h0, 1, 4'd15, 32'h0, 0, 0, 4'd0, 32'h0, 1, 1, 2'b01, 0), "load_bad");
    apply(mk(0, 0, 4'd0, 32'h0, 0, 4'd0,  32'h0, 0, 0, 4'd0, 32'h0, 1, 1, 2'b01, 1), "load_sticky");
    apply(mk(1, 0, 4'd0, 32'h0, 0, 4'd0,  32'h0, 0, 0, 4'd0, 32'h0, 1, 1, 2'b01, 1), "rst_load");
    sweep(15, 1'b0, "clr2");
    apply(mk(0, 0, 4'd0, 32'h0, 1, 4'd0, 32'hCAFE0000, 1,
             1, 4'd0, 32'hCAFE0000, 1, 1, 2'b01, 0), "load_done");
    apply(mk(0, 1, 4'd15, 32'h77, 0, 4'd0, 32'h0, 0, 0, 4'd0, 32'h0, 0, 0, 2'b10, 0), "run_bad");
    apply(mk(0, 0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 0, 0, 4'd0, 32'h0, HOST_RUN, 0, 2'b10, 1), "run_sticky");

    // Randomized RUN traffic against rule-level expectations.
    m_err = 1'b1;
    for (int i = 0; i < 300; i++) begin
      cwe = 1'($urandom_range(0, 1));
      cwa = (($urandom_range(0, 7)) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
      cwd = $urandom;
      hv  = 1'($urandom_range(0, 1));
      ha  = (($urandom_range(0, 7)) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
      hd  = $urandom;
      hr    = HOST_RUN && !cwe;
      cw_ok = cwe && (cwa < 4'd15);
      hw_ok = hr && hv && (ha < 4'd15);
      v = mk(0, cwe, cwa, cwd, hv, ha, hd, 1'($urandom_range(0, 1)),
             cw_ok || hw_ok, cw_ok ? cwa : ha, cw_ok ? cwd : hd, hr, 0, 2'b10, m_err);
      apply(v, $sformatf("rnd[%0d]", i));
      if ((cwe && cwa == 4'd15) || (hr && hv && ha == 4'd15)) m_err = 1'b1;
    end

    for (int i = 0; i < 15; i++)
      cmp($sformatf("regfile[r%0d]", i), dmem[i], mmem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
